// File: rtl/mux16_word_serializer_pkg.sv
// Shared constants and types for the 16-bit word serializer.
// State encoding and widths used by the sequencer and mux.
package mux16_word_serializer_pkg;

   localparam int SEL_W  = 4;
   localparam int WORD_W = 16;

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   typedef logic [0:WORD_W-1] word_t;
   typedef logic [SEL_W-1:0]  sel_t;

endpackage

// File: rtl/mux16_word_serializer_mux.sv
// 16-to-1 function mux: f = w[s], bit index i is input i.
// Pure combinational data path used by the serializer.
module mux16to1_function
   import mux16_word_serializer_pkg::*;
(
   input  word_t w,
   input  sel_t  s,
   output logic  f
);

   assign f = w[s];

endmodule

// File: rtl/mux16_word_serializer.sv
// Parallel-to-serial converter: holds a word and steps the mux
// select through all 16 positions, BIT_CYCLES clocks per bit.
module mux16_word_serializer
   import mux16_word_serializer_pkg::*;
#(
   parameter bit DESCEND    = 1'b0,
   parameter int BIT_CYCLES = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_valid,
   input  logic [0:15] load_data,
   output logic        load_ready,
   input  logic        abort,
   output logic [3:0]  sel,
   output logic        ser_out,
   output logic        ser_valid,
   output logic        ser_last,
   output logic        busy
);

   localparam sel_t SEL_START = DESCEND ? 4'd15 : 4'd0;
   localparam sel_t SEL_END   = DESCEND ? 4'd0 : 4'd15;
   localparam sel_t LAST_HOLD = 4'(BIT_CYCLES - 1);

   logic  state;
   word_t word_reg;
   sel_t  hold_cnt;
   logic  bit_done;
   logic  word_done;
   logic  accept;

   assign bit_done  = (hold_cnt == LAST_HOLD);
   assign busy      = (state == ST_SHIFT);
   assign ser_valid = busy;
   assign ser_last  = busy & (sel == SEL_END);
   assign word_done = ser_last & bit_done;

   // abort frees the slot at once so a waiting word restarts
   // the stream without an idle cycle
   assign load_ready = (state == ST_IDLE) | word_done | abort;
   assign accept     = load_valid & load_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         word_reg <= '0;
         sel      <= SEL_START;
         hold_cnt <= '0;
      end else if (accept) begin
         state    <= ST_SHIFT;
         word_reg <= load_data;
         sel      <= SEL_START;
         hold_cnt <= '0;
      end else if (state == ST_SHIFT) begin
         if (abort | word_done) begin
            state    <= ST_IDLE;
            word_reg <= '0;
            sel      <= SEL_START;
            hold_cnt <= '0;
         end else if (bit_done) begin
            hold_cnt <= '0;
            sel      <= DESCEND ? sel - 4'd1 : sel + 4'd1;
         end else begin
            hold_cnt <= hold_cnt + 4'd1;
         end
      end
   end

   mux16to1_function u_mux (
      .w (word_reg),
      .s (sel),
      .f (ser_out)
   );

endmodule

// File: tb/tb_mux16_word_serializer.sv
// Bench for mux16_word_serializer: two configurations checked
// cycle by cycle against a bit-position reference model.
module tb_mux16_word_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        lv [2];
   logic [0:15] ld [2];
   logic        ab [2];
   logic        rdy [2];
   logic [3:0]  sel [2];
   logic        so [2];
   logic        sv [2];
   logic        sl [2];
   logic        bz [2];

   int total = 0;
   int bad   = 0;

   bit          m_busy [2];
   logic [0:15] m_word [2];
   int          m_pos  [2];
   int          m_rep  [2];
   bit          m_acc  [2];

   always #5 clk = ~clk;

   mux16_word_serializer #(.DESCEND(1'b0), .BIT_CYCLES(1)) u0 (
      .clk(clk), .rst(rst),
      .load_valid(lv[0]), .load_data(ld[0]), .load_ready(rdy[0]),
      .abort(ab[0]), .sel(sel[0]), .ser_out(so[0]),
      .ser_valid(sv[0]), .ser_last(sl[0]), .busy(bz[0])
   );

   mux16_word_serializer #(.DESCEND(1'b1), .BIT_CYCLES(3)) u1 (
      .clk(clk), .rst(rst),
      .load_valid(lv[1]), .load_data(ld[1]), .load_ready(rdy[1]),
      .abort(ab[1]), .sel(sel[1]), .ser_out(so[1]),
      .ser_valid(sv[1]), .ser_last(sl[1]), .busy(bz[1])
   );

   function automatic int bc(int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic bit desc(int k);
      return k != 0;
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_busy[k] = 1'b0;
         m_word[k] = '0;
         m_pos[k]  = 0;
         m_rep[k]  = 0;
         m_acc[k]  = 1'b0;
      end
   endtask

   task automatic expect_outputs(int k);
      int  s;
      bit  eo;
      bit  er;
      bit  el;
      if (m_busy[k]) s = desc(k) ? 15 - m_pos[k] : m_pos[k];
      else           s = desc(k) ? 15 : 0;
      eo = m_busy[k] ? m_word[k][s] : 1'b0;
      el = m_busy[k] && (m_pos[k] == 15);
      er = !m_busy[k] || (el && m_rep[k] == bc(k) - 1) || ab[k];
      check($sformatf("u%0d.sel", k), 32'(sel[k]), 32'(s));
      check($sformatf("u%0d.ser_out", k), 32'(so[k]), 32'(eo));
      check($sformatf("u%0d.ser_valid", k), 32'(sv[k]), 32'(m_busy[k]));
      check($sformatf("u%0d.ser_last", k), 32'(sl[k]), 32'(el));
      check($sformatf("u%0d.busy", k), 32'(bz[k]), 32'(m_busy[k]));
      check($sformatf("u%0d.load_ready", k), 32'(rdy[k]), 32'(er));
      m_acc[k] = lv[k] && er;
   endtask

   task automatic tick();
      #1;
      for (int k = 0; k < 2; k++) expect_outputs(k);
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (m_acc[k]) begin
            m_busy[k] = 1'b1;
            m_word[k] = ld[k];
            m_pos[k]  = 0;
            m_rep[k]  = 0;
         end else if (m_busy[k]) begin
            if (ab[k]) begin
               m_busy[k] = 1'b0;
            end else if (m_rep[k] == bc(k) - 1) begin
               m_rep[k] = 0;
               if (m_pos[k] == 15) m_busy[k] = 1'b0;
               else m_pos[k]++;
            end else begin
               m_rep[k]++;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic quiet();
      for (int k = 0; k < 2; k++) begin
         lv[k] = 1'b0;
         ab[k] = 1'b0;
         ld[k] = 16'($urandom);
      end
   endtask

   task automatic idle_ticks(int n);
      quiet();
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic load(int k, logic [0:15] w);
      quiet();
      lv[k] = 1'b1;
      ld[k] = w;
      tick();
      check($sformatf("u%0d.accept", k), 32'(m_acc[k]), 32'd1);
      quiet();
   endtask

   task automatic run_to_pos(int k, int p);
      int guard = 0;
      quiet();
      while (!(m_busy[k] && m_pos[k] == p) && guard < 100) begin
         tick();
         guard++;
      end
      check($sformatf("u%0d.reach_pos%0d", k, p), 32'(guard < 100), 32'd1);
   endtask

   initial begin
      logic [0:15] bb [2];
      int i;
      int guard;

      rst = 1'b1;
      model_reset();
      quiet();
      #3;
      for (int k = 0; k < 2; k++) expect_outputs(k);
      @(negedge clk);
      rst = 1'b0;

      load(0, 16'b0101010101010101);
      idle_ticks(18);

      bb[0] = 16'hFFFF;
      bb[1] = 16'h0000;
      i = 0;
      guard = 0;
      while (i < 2 && guard < 100) begin
         quiet();
         lv[0] = 1'b1;
         ld[0] = bb[i];
         tick();
         if (m_acc[0]) i++;
         guard++;
      end
      check("u0.b2b_accepts", 32'(i), 32'd2);
      idle_ticks(34);

      load(1, 16'h8001);
      idle_ticks(50);

      load(0, 16'($urandom));
      run_to_pos(0, 5);
      ab[0] = 1'b1;
      tick();
      idle_ticks(2);

      load(0, 16'($urandom));
      run_to_pos(0, 5);
      ab[0] = 1'b1;
      lv[0] = 1'b1;
      ld[0] = 16'hAAAA;
      tick();
      check("u0.abort_reload", 32'(m_acc[0]), 32'd1);
      idle_ticks(20);

      load(0, 16'hC3A5);
      load(1, 16'h5AF0);
      idle_ticks(4);
      lv[0] = 1'b1;
      ld[0] = 16'hFFFF;
      lv[1] = 1'b1;
      ld[1] = 16'h0000;
      tick();
      check("u0.midword_no_accept", 32'(m_acc[0]), 32'd0);
      check("u1.midword_no_accept", 32'(m_acc[1]), 32'd0);
      idle_ticks(50);

      load(0, 16'($urandom));
      load(1, 16'($urandom));
      run_to_pos(0, 9);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      for (int k = 0; k < 2; k++) expect_outputs(k);
      @(negedge clk);
      rst = 1'b0;
      idle_ticks(5);

      for (int n = 0; n < 3000; n++) begin
         for (int k = 0; k < 2; k++) begin
            lv[k] = ($urandom_range(0, 3) == 0);
            ab[k] = ($urandom_range(0, 31) == 0);
            ld[k] = 16'($urandom);
         end
         tick();
      end
      idle_ticks(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
